display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/disp_pkg.sv | 35 +++
 rtl/bin2bcd_seq.sv | 49 ++++
 rtl/display_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed two-digit display controller:
// FSM state encoding, 7-segment codes (gfedcba, active-low) and the input clamp value.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_UPDATE  = 2'd2
  } state_t;

  localparam logic [6:0] MAX_VAL   = 7'd99;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry [d] is the active-low gfedcba pattern for decimal digit d.
  localparam logic [9:0][6:0] SEG_CODE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    if (digit <= 4'd9) begin
      return SEG_CODE[digit];
    end
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 7-bit binary to two BCD digits, one bit per cycle,
// MSB first; done rises with the seventh shift and holds until the next start.
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] bin,
  output logic [7:0] bcd,
  output logic       done
);

  // Upper byte accumulates BCD, lower 7 bits hold the remaining binary operand.
  logic [14:0] work;
  logic [7:0]  adj;
  logic [2:0]  cnt;
  logic        active;

  always_comb begin
    adj = work[14:7];
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else if (start) begin
      work   <= {8'd0, bin};
      cnt    <= '0;
      active <= 1'b1;
      done   <= 1'b0;
    end else if (active) begin
      work <= {adj, work[6:0]} << 1;
      cnt  <= cnt + 3'd1;
      if (cnt == 3'd6) begin
        active <= 1'b0;
        done   <= 1'b1;
      end
    end
  end

  assign bcd = work[14:7];

endmodule

// File: rtl/display_scan_ctrl.sv
// Captures a 0-99 value, converts it to BCD and scans it onto a 4-digit common-anode display.
// Build option: DISP_LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 12500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] bin_in,
  input  logic       load,
  output logic       busy,
  output logic       valid,
  output logic       ovf,
  output logic [6:0] seg_out,
  output logic [3:0] sel
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t      state, state_nxt;
  logic [2:0]  conv_cnt, conv_cnt_nxt;
  logic        start;
  logic [6:0]  bin_clamped;
  logic [7:0]  bcd;
  logic        bcd_done;
  logic [3:0]  units, tens;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic          terminal;
  logic [6:0]    tens_seg;
  logic [6:0]    slot_seg;

  assign bin_clamped = (bin_in > MAX_VAL) ? MAX_VAL : bin_in;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin_clamped),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  // The converter shifts on the same edges as CONVERT cycles 2..7 plus the exit edge,
  // so its result is ready during UPDATE.
  always_comb begin
    state_nxt    = state;
    conv_cnt_nxt = conv_cnt;
    start        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          start        = 1'b1;
          conv_cnt_nxt = '0;
          state_nxt    = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        conv_cnt_nxt = conv_cnt + 3'd1;
        if (conv_cnt == 3'd6) state_nxt = ST_UPDATE;
      end
      ST_UPDATE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      conv_cnt <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      units    <= '0;
      tens     <= '0;
    end else begin
      state    <= state_nxt;
      conv_cnt <= conv_cnt_nxt;
      busy     <= (state_nxt != ST_IDLE);
      valid    <= (state == ST_UPDATE);
      if (start) ovf <= (bin_in > MAX_VAL);
      if (state == ST_UPDATE && bcd_done) begin
        tens  <= bcd[7:4];
        units <= bcd[3:0];
      end
    end
  end

`ifdef DISP_LEADING_ZERO_BLANK_EN
  assign tens_seg = (tens == 4'd0) ? SEG_BLANK : seg_encode(tens);
`else
  assign tens_seg = seg_encode(tens);
`endif

  always_comb begin
    slot_seg = SEG_BLANK;
    case (idx)
      2'd0:    slot_seg = seg_encode(units);
      2'd1:    slot_seg = tens_seg;
      default: slot_seg = SEG_BLANK;
    endcase
  end

  assign terminal = (presc == PW'(REFRESH_DIV - 1));

  // sel and seg_out load together from the same index, then the index moves on;
  // this keeps the display dark until the first terminal count after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      idx     <= '0;
      sel     <= 4'b1111;
      seg_out <= SEG_BLANK;
    end else if (terminal) begin
      presc   <= '0;
      idx     <= idx + 2'd1;
      sel     <= ~(4'b0001 << idx);
      seg_out <= slot_seg;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl with REFRESH_DIV=4.
module tb_display_scan_ctrl;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S9 = 7'b0010000;
  localparam logic [6:0] BLK = 7'b1111111;
`ifdef DISP_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TENS_ZERO = BLK;
`else
  localparam logic [6:0] TENS_ZERO = S0;
`endif

  logic       clk;
  logic       rst_n;
  logic [6:0] bin_in;
  logic       load;
  logic       busy, valid, ovf;
  logic [6:0] seg_out;
  logic [3:0] sel;

  int unsigned checks = 0;
  int unsigned errors = 0;

  display_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bin_in  (bin_in),
    .load    (load),
    .busy    (busy),
    .valid   (valid),
    .ovf     (ovf),
    .seg_out (seg_out),
    .sel     (sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [6:0] v);
    bin_in = v;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  // Lets any stale slot drain, then scans one full frame checking each slot.
  task automatic check_display(input string tag, input logic [6:0] u, input logic [6:0] t);
    logic seen_u, seen_t;
    seen_u = 1'b0;
    seen_t = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 16; i++) begin
      case (sel)
        4'b1110: begin check({tag, "_units"}, 8'(seg_out), 8'(u)); seen_u = 1'b1; end
        4'b1101: begin check({tag, "_tens"}, 8'(seg_out), 8'(t)); seen_t = 1'b1; end
        4'b1011, 4'b0111: check({tag, "_blank"}, 8'(seg_out), 8'(BLK));
        default: check({tag, "_sel_onehot"}, 8'(sel), 8'h0E);
      endcase
      tick();
    end
    check({tag, "_slots_seen"}, 8'({seen_u, seen_t}), 8'h03);
  endtask

  initial begin
    int unsigned nvalid;
    logic [3:0] exp_sel;
    logic [6:0] exp_seg;
    int unsigned s;

    rst_n  = 1'b1;
    bin_in = '0;
    load   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_valid", 8'(valid), 8'h00);
    check("rst_ovf", 8'(ovf), 8'h00);
    check("rst_sel", 8'(sel), 8'h0F);
    check("rst_seg", 8'(seg_out), 8'(BLK));
    tick();
    tick();
    rst_n = 1'b1;

    // Scan from reset: dark for 3 edges, 1110 at the 4th, then 4-cycle slots.
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (k < 4) begin
        exp_sel = 4'b1111;
        exp_seg = BLK;
      end else begin
        s = ((k - 4) / 4) % 4;
        exp_sel = ~(4'b0001 << s);
        exp_seg = (s == 0) ? S0 : (s == 1) ? TENS_ZERO : BLK;
      end
      check("scan_sel", 8'(sel), 8'(exp_sel));
      check("scan_seg", 8'(seg_out), 8'(exp_seg));
    end

    // 42: busy for exactly 8 cycles, valid on the 8th edge after the load edge.
    do_load(7'd42);
    for (int i = 0; i < 8; i++) begin
      check("l42_busy", 8'(busy), 8'h01);
      check("l42_valid_early", 8'(valid), 8'h00);
      tick();
    end
    check("l42_busy_end", 8'(busy), 8'h00);
    check("l42_valid", 8'(valid), 8'h01);
    check("l42_ovf", 8'(ovf), 8'h00);
    tick();
    check("l42_valid_pulse", 8'(valid), 8'h00);
    check_display("d42", S2, S4);

    do_load(7'd5);
    repeat (9) tick();
    check_display("d05", S5, TENS_ZERO);

    do_load(7'd120);
    check("l120_ovf", 8'(ovf), 8'h01);
    repeat (9) tick();
    check_display("d120", S9, S9);
    do_load(7'd15);
    check("l15_ovf", 8'(ovf), 8'h00);
    repeat (9) tick();
    check_display("d15", S5, S1);

    // Second load two cycles into a conversion must be dropped.
    do_load(7'd42);
    tick();
    bin_in = 7'd7;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid) nvalid++;
      tick();
    end
    check("busy_load_valid_count", 8'(nvalid), 8'd1);
    check("busy_load_ovf", 8'(ovf), 8'h00);
    check_display("d42b", S2, S4);

    // Reset during the third CONVERT cycle aborts everything.
    do_load(7'd120);
    check("abort_ovf_set", 8'(ovf), 8'h01);
    tick();
    tick();
    check("abort_busy_before", 8'(busy), 8'h01);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 8'(busy), 8'h00);
    check("abort_valid", 8'(valid), 8'h00);
    check("abort_ovf", 8'(ovf), 8'h00);
    check("abort_sel", 8'(sel), 8'h0F);
    check("abort_seg", 8'(seg_out), 8'(BLK));
    tick();
    tick();
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid) nvalid++;
      tick();
    end
    check("abort_no_valid", 8'(nvalid), 8'd0);
    check("abort_idle", 8'(busy), 8'h00);
    check_display("d_abort", S0, TENS_ZERO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
